// File: rtl/prt_scaler_vps_shadow.sv
// VPS shadow register: collects one in-order sweep of parameter words into a
// staging bank and applies it to the active bank on the next qualified frame start.
module prt_scaler_vps_shadow #(
  parameter int P_IDX_WIDTH = 4,
  parameter int P_DAT_WIDTH = 16,
  parameter int P_NUM       = 16
) (
  input  logic                         VID_CLK_IN,
  input  logic                         VID_RST_IN,
  input  logic                         CTL_RUN_IN,
  input  logic [P_IDX_WIDTH-1:0]       VPS_IDX_IN,
  input  logic [P_DAT_WIDTH-1:0]       VPS_DAT_IN,
  input  logic                         VPS_VLD_IN,
  input  logic                         VID_VS_IN,
  output logic [P_NUM*P_DAT_WIDTH-1:0] VPS_DAT_OUT,
  output logic                         VPS_RDY_OUT,
  output logic                         VPS_UPD_OUT,
  output logic [7:0]                   VPS_ERR_OUT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_FILL = 2'd2,
    ST_FULL = 2'd3
  } state_t;

  localparam int                  LP_CW   = P_IDX_WIDTH + 1;
  localparam logic [LP_CW-1:0]    LP_LAST = LP_CW'(P_NUM - 1);
  localparam logic [P_IDX_WIDTH-1:0] LP_IDX_ZERO = {P_IDX_WIDTH{1'b0}};
  localparam logic [P_IDX_WIDTH-1:0] LP_IDX_ONE  = {{(P_IDX_WIDTH-1){1'b0}}, 1'b1};

  state_t                       state_r;
  logic [P_IDX_WIDTH-1:0]       exp_r;
  logic [P_NUM*P_DAT_WIDTH-1:0] stage_r;
  logic [P_NUM*P_DAT_WIDTH-1:0] act_r;
  logic                         rdy_r;
  logic                         upd_r;
  logic                         vs_q_r;
  logic [7:0]                   err_r;

  logic                         vs_edge_s;
  logic                         idx_zero_s;
  logic                         idx_hit_s;
  logic                         exp_last_s;
  logic                         stg_we_s;
  logic                         stg_at0_s;
  logic [P_IDX_WIDTH-1:0]       stg_addr_s;

  // Input qualifiers shared by the staging write decode and the state machine.
  always_comb begin
    vs_edge_s  = VID_VS_IN & ~vs_q_r;
    idx_zero_s = (VPS_IDX_IN == LP_IDX_ZERO);
    idx_hit_s  = (VPS_IDX_IN == exp_r);
    exp_last_s = ({1'b0, exp_r} == LP_LAST);
  end

  // Staging write decode: an in-order word, or an index-0 word that (re)starts a sweep.
  always_comb begin
    stg_we_s  = 1'b0;
    stg_at0_s = 1'b0;
    if (!VID_RST_IN && CTL_RUN_IN && VPS_VLD_IN) begin
      case (state_r)
        ST_SYNC: begin
          stg_we_s  = idx_zero_s;
          stg_at0_s = 1'b1;
        end
        ST_FILL: begin
          if (idx_hit_s) begin
            stg_we_s  = 1'b1;
            stg_at0_s = 1'b0;
          end else begin
            stg_we_s  = idx_zero_s;
            stg_at0_s = 1'b1;
          end
        end
        default: begin
          stg_we_s  = 1'b0;
          stg_at0_s = 1'b0;
        end
      endcase
    end else begin
      stg_we_s  = 1'b0;
      stg_at0_s = 1'b0;
    end
    stg_addr_s = stg_at0_s ? LP_IDX_ZERO : exp_r;
  end

  // Staging bank; no reset since every word is rewritten before it can be applied.
  always_ff @(posedge VID_CLK_IN) begin
    if (stg_we_s) begin
      stage_r[int'(stg_addr_s)*P_DAT_WIDTH +: P_DAT_WIDTH] <= VPS_DAT_IN;
    end
  end

  // Sweep sequencing, frame-start apply and error counting.
  always_ff @(posedge VID_CLK_IN) begin
    if (VID_RST_IN) begin
      state_r <= ST_IDLE;
      exp_r   <= LP_IDX_ZERO;
      act_r   <= {(P_NUM*P_DAT_WIDTH){1'b0}};
      rdy_r   <= 1'b0;
      upd_r   <= 1'b0;
      err_r   <= 8'd0;
      vs_q_r  <= 1'b1;
    end else begin
      vs_q_r <= VID_VS_IN;
      upd_r  <= 1'b0;
      if (!CTL_RUN_IN) begin
        state_r <= ST_IDLE;
        rdy_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_SYNC;
          end
          ST_SYNC: begin
            if (VPS_VLD_IN && idx_zero_s) begin
              exp_r   <= LP_IDX_ONE;
              state_r <= (P_NUM == 1) ? ST_FULL : ST_FILL;
            end
          end
          ST_FILL: begin
            if (VPS_VLD_IN) begin
              if (idx_hit_s) begin
                exp_r <= exp_r + LP_IDX_ONE;
                if (exp_last_s) begin
                  state_r <= ST_FULL;
                end
              end else begin
                // Out-of-order word: the partial set is dropped.
                err_r <= (err_r == 8'hFF) ? err_r : err_r + 8'd1;
                if (idx_zero_s) begin
                  exp_r <= LP_IDX_ONE;
                end else begin
                  state_r <= ST_SYNC;
                end
              end
            end
          end
          ST_FULL: begin
            if (vs_edge_s) begin
              act_r   <= stage_r;
              upd_r   <= 1'b1;
              rdy_r   <= 1'b1;
              state_r <= ST_SYNC;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign VPS_DAT_OUT = act_r;
  assign VPS_RDY_OUT = rdy_r;
  assign VPS_UPD_OUT = upd_r;
  assign VPS_ERR_OUT = err_r;

endmodule

// File: tb/tb_prt_scaler_vps_shadow.sv
// Self-checking bench for prt_scaler_vps_shadow: directed scenarios plus a
// randomized run checked cycle by cycle against a behavioural model.
module tb_prt_scaler_vps_shadow;

  localparam int IW = 4;
  localparam int DW = 16;
  localparam int N  = 16;

  logic            clk;
  logic            rst;
  logic            run;
  logic [IW-1:0]   idx;
  logic [DW-1:0]   dat;
  logic            vld;
  logic            vs;
  logic [N*DW-1:0] dout;
  logic            rdy;
  logic            upd;
  logic [7:0]      err;

  int errors = 0;
  int checks = 0;

  // Behavioural model: m_nxt = -1 while hunting for index 0, N once a sweep is complete.
  int          m_nxt;
  bit          m_idle;
  logic [15:0] m_stg [N];
  logic [15:0] m_act [N];
  logic        m_rdy;
  logic        m_upd;
  int          m_err;
  logic        m_vsp;

  prt_scaler_vps_shadow #(.P_IDX_WIDTH(IW), .P_DAT_WIDTH(DW), .P_NUM(N)) dut (
    .VID_CLK_IN (clk),
    .VID_RST_IN (rst),
    .CTL_RUN_IN (run),
    .VPS_IDX_IN (idx),
    .VPS_DAT_IN (dat),
    .VPS_VLD_IN (vld),
    .VID_VS_IN  (vs),
    .VPS_DAT_OUT(dout),
    .VPS_RDY_OUT(rdy),
    .VPS_UPD_OUT(upd),
    .VPS_ERR_OUT(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [N*DW-1:0] model_dat();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = m_act[i];
    return v;
  endfunction

  function automatic logic [15:0] word(input int i);
    return dout[i*DW +: DW];
  endfunction

  task automatic model_step();
    logic e;
    e     = vs && !m_vsp;
    m_vsp = vs;
    m_upd = 1'b0;
    if (rst) begin
      m_nxt = -1; m_idle = 1'b1; m_rdy = 1'b0; m_err = 0; m_vsp = 1'b1;
      for (int i = 0; i < N; i++) m_act[i] = 16'h0000;
    end else if (!run) begin
      m_idle = 1'b1; m_rdy = 1'b0; m_nxt = -1;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_nxt == N) begin
      if (e) begin
        for (int i = 0; i < N; i++) m_act[i] = m_stg[i];
        m_upd = 1'b1; m_rdy = 1'b1; m_nxt = -1;
      end
    end else if (vld) begin
      if (m_nxt < 0) begin
        if (idx == 0) begin m_stg[0] = dat; m_nxt = 1; end
      end else if (int'(idx) == m_nxt) begin
        m_stg[idx] = dat; m_nxt++;
      end else begin
        if (m_err < 255) m_err++;
        if (idx == 0) begin m_stg[0] = dat; m_nxt = 1; end
        else m_nxt = -1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input int i, input int d);
    vld = 1'b1; idx = IW'(i); dat = DW'(d);
    tick();
    vld = 1'b0;
  endtask

  task automatic sweep(input int base, input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) begin
      send(i, base + i);
      if (gaps) tick();
    end
  endtask

  task automatic idle_n(input int n);
    vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0;
    tick(); tick();
    rst = 1'b0; run = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    vs = 1'b1; run = 1'b1;
    rst = 1'b1; tick(); tick();
    checks++; if (dout !== '0) begin errors++; $display("FAIL rst_dat got=%h want=0", dout); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rst_rdy got=%b want=0", rdy); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL rst_upd got=%b want=0", upd); end
    checks++; if (err !== 8'd0) begin errors++; $display("FAIL rst_err got=%0d want=0", err); end
    rst = 1'b0; tick();
    sweep(16'h3000, 0, 7, 1'b0);
    rst = 1'b1; tick(); tick();
    rst = 1'b0; tick();
    checks++; if (dout !== '0 || rdy !== 1'b0 || err !== 8'd0)
      begin errors++; $display("FAIL midfill_rst got dat=%h rdy=%b err=%0d want 0", dout, rdy, err); end
    sweep(16'h3000, 0, 15, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (upd !== 1'b0 || rdy !== 1'b0)
        begin errors++; $display("FAIL vs_high_upd got upd=%b rdy=%b want 0 0", upd, rdy); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    vs = 1'b0; do_reset();
    sweep(16'h1000, 0, 15, 1'b0);
    idle_n(5);
    vs = 1'b1; tick();
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL b2b_upd got=%b want=1", upd); end
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy got=%b want=1", rdy); end
    checks++; if (word(7) !== 16'h1007) begin errors++; $display("FAIL b2b_w7 got=%h want=1007", word(7)); end
    checks++; if (err !== 8'd0) begin errors++; $display("FAIL b2b_err got=%0d want=0", err); end
    checks++; if (dout !== model_dat()) begin errors++; $display("FAIL b2b_dat got=%h want=%h", dout, model_dat()); end
    tick();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL b2b_upd_off got=%b want=0", upd); end
    vs = 1'b0;
  endtask

  task automatic test_gaps();
    sweep(16'h5000, 0, 15, 1'b1);
    idle_n(2);
    vs = 1'b1; tick();
    checks++; if (upd !== 1'b1 || rdy !== 1'b1) begin errors++; $display("FAIL gap_upd got upd=%b rdy=%b want 1 1", upd, rdy); end
    checks++; if (word(7) !== 16'h5007 || word(15) !== 16'h500F)
      begin errors++; $display("FAIL gap_words got w7=%h w15=%h want 5007 500f", word(7), word(15)); end
    checks++; if (err !== 8'd0) begin errors++; $display("FAIL gap_err got=%0d want=0", err); end
    vs = 1'b0; tick();
  endtask

  task automatic test_misaligned();
    vs = 1'b0; do_reset();
    sweep(16'h1000, 9, 15, 1'b0);
    sweep(16'h1000, 0, 15, 1'b0);
    idle_n(2);
    vs = 1'b1; tick();
    checks++; if (err !== 8'd0) begin errors++; $display("FAIL mis_err got=%0d want=0", err); end
    checks++; if (word(0) !== 16'h1000 || word(9) !== 16'h1009)
      begin errors++; $display("FAIL mis_words got w0=%h w9=%h want 1000 1009", word(0), word(9)); end
    checks++; if (dout !== model_dat()) begin errors++; $display("FAIL mis_dat got=%h want=%h", dout, model_dat()); end
    vs = 1'b0;
    send(0, 0); send(1, 1); send(2, 2); send(5, 5);
    checks++; if (err !== 8'd1) begin errors++; $display("FAIL seq_err got=%0d want=1", err); end
    send(6, 6); send(7, 7);
    checks++; if (err !== 8'd1) begin errors++; $display("FAIL seq_sync got=%0d want=1", err); end
  endtask

  task automatic test_final_word_vs();
    vs = 1'b0; do_reset();
    sweep(16'h1000, 0, 14, 1'b0);
    vs = 1'b1; tick();
    send(15, 16'h100F);
    idle_n(3);
    checks++; if (upd !== 1'b0 || rdy !== 1'b0 || dout !== '0)
      begin errors++; $display("FAIL early_vs got upd=%b rdy=%b dat=%h want 0 0 0", upd, rdy, dout); end
    vs = 1'b0; tick();
    vs = 1'b1; tick();
    checks++; if (upd !== 1'b1 || rdy !== 1'b1 || word(15) !== 16'h100F)
      begin errors++; $display("FAIL late_vs got upd=%b rdy=%b w15=%h want 1 1 100f", upd, rdy, word(15)); end
    vs = 1'b0;
    sweep(16'h4000, 0, 14, 1'b0);
    vs = 1'b1; send(15, 16'h400F);
    tick();
    checks++; if (upd !== 1'b0 || word(3) !== 16'h1003)
      begin errors++; $display("FAIL same_cyc got upd=%b w3=%h want 0 1003", upd, word(3)); end
    vs = 1'b0; tick();
    vs = 1'b1; tick();
    checks++; if (upd !== 1'b1 || word(3) !== 16'h4003)
      begin errors++; $display("FAIL same_cyc_next got upd=%b w3=%h want 1 4003", upd, word(3)); end
    vs = 1'b0;
  endtask

  task automatic test_run_drop();
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rdy !== 1'b0 || word(3) !== 16'h4003)
        begin errors++; $display("FAIL drop got rdy=%b w3=%h want 0 4003", rdy, word(3)); end
    end
    run = 1'b1; tick();
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL drop_after got=%b want=0", rdy); end
    sweep(16'h2000, 0, 15, 1'b0);
    vs = 1'b1; tick();
    checks++; if (rdy !== 1'b1 || word(7) !== 16'h2007)
      begin errors++; $display("FAIL drop_resume got rdy=%b w7=%h want 1 2007", rdy, word(7)); end
    vs = 1'b0; tick();
    sweep(16'h6000, 0, 15, 1'b0);
    vs = 1'b1; run = 1'b0; tick();
    checks++; if (upd !== 1'b0 || rdy !== 1'b0 || word(7) !== 16'h2007)
      begin errors++; $display("FAIL run_vs got upd=%b rdy=%b w7=%h want 0 0 2007", upd, rdy, word(7)); end
    vs = 1'b0; run = 1'b1; tick();
  endtask

  task automatic test_random();
    int src;
    int hold;
    vs = 1'b0; do_reset();
    src = 0; hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold > 0) begin hold--; run = 1'b0; end
      else if ($urandom_range(0, 299) == 0) begin hold = $urandom_range(1, 4); run = 1'b0; end
      else run = 1'b1;
      if ($urandom_range(0, 39) == 0) vs = ~vs;
      vld = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) idx = IW'($urandom_range(0, N-1));
      else idx = IW'(src);
      dat = DW'($urandom);
      if (vld) src = (src + 1) % N;
      tick();
      checks++;
      if (dout !== model_dat() || rdy !== m_rdy || upd !== m_upd || err !== 8'(m_err)) begin
        errors++;
        $display("FAIL rand c=%0d got rdy=%b upd=%b err=%0d want rdy=%b upd=%b err=%0d dat_ok=%0b",
                 c, rdy, upd, err, m_rdy, m_upd, m_err, dout === model_dat());
      end
    end
    vld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; vld = 1'b0; idx = '0; dat = '0; vs = 1'b1;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_misaligned();
    test_final_word_vs();
    test_run_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
